// File: rtl/dcache_ctrl.sv
// Blocking, direct-mapped, write-through, no-write-allocate data cache
// controller for the memory stage. Line fills are four in-order beats on a
// 32-bit single-beat handshake bus; stores go out one word per beat.
module dcache_ctrl #(
    parameter int ADDR_W = 36,
    parameter int SETS   = 16,
    parameter int BEAT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [4*BEAT_W-1:0] req_wdata,
    input  logic [3:0]          req_wmask,
    output logic                stall,
    output logic [4*BEAT_W-1:0] line_data,
    output logic [1:0]          line_offset,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_write,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [BEAT_W-1:0]   mem_req_wdata,
    input  logic                mem_resp_valid,
    input  logic [BEAT_W-1:0]   mem_resp_data,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL_REQ  = 3'd1,
        ST_FILL_WAIT = 3'd2,
        ST_WR_SEND   = 3'd3,
        ST_WR_DONE   = 3'd4
    } state_t;

    // Lowest set bit of a 4-bit mask; stores go out in ascending word order.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] k;
        if (m[0]) begin
            k = 2'd0;
        end else if (m[1]) begin
            k = 2'd1;
        end else if (m[2]) begin
            k = 2'd2;
        end else if (m[3]) begin
            k = 2'd3;
        end else begin
            k = 2'd0;
        end
        return k;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SETS-1:0]     r_valid;
    logic [TAG_W-1:0]    r_tag  [SETS];
    logic [BEAT_W-1:0]   r_data [SETS][4];
    logic [3:0]          r_pend_mask;
    logic [1:0]          r_beat_cnt;
    logic [BEAT_W-1:0]   r_fill_w0;
    logic [BEAT_W-1:0]   r_fill_w1;
    logic [BEAT_W-1:0]   r_fill_w2;
    logic                r_refill;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic [IDX_W-1:0]    w_index;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic [1:0]          w_k;
    logic [3:0]          w_pend_after;
    logic [BEAT_W-1:0]   w_req_word [4];
    logic                w_stall;
    logic                w_mem_valid;
    logic                w_mem_write;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [BEAT_W-1:0]   w_mem_wdata;
    logic                w_hit_inc;
    logic                w_miss_inc;
    logic                w_pend_load;
    logic                w_pend_clear;
    logic                w_fill_start;
    logic                w_beat_take;
    logic                w_fill_done;
    logic                w_wr_merge;

    assign w_index      = req_addr[IDX_W+1:2];
    assign w_tag        = req_addr[ADDR_W-1:IDX_W+2];
    assign w_hit        = req_valid & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_k          = lowest_set(r_pend_mask);
    assign w_pend_after = r_pend_mask & ~(4'b0001 << w_k);

    assign line_data     = {r_data[w_index][3], r_data[w_index][2],
                            r_data[w_index][1], r_data[w_index][0]};
    assign line_offset   = req_addr[1:0];
    assign stall         = w_stall;
    assign mem_req_valid = w_mem_valid;
    assign mem_req_write = w_mem_write;
    assign mem_req_addr  = w_mem_addr;
    assign mem_req_wdata = w_mem_wdata;
    assign hit_count     = r_hit_count;
    assign miss_count    = r_miss_count;

    // Split the store data into its four words for beat selection.
    always_comb begin
        for (int w = 0; w < 4; w++) begin
            w_req_word[w] = req_wdata[w*BEAT_W +: BEAT_W];
        end
    end

    // Next-state, stall and memory-bus drive for the controller FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_stall      = 1'b0;
        w_mem_valid  = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_pend_load  = 1'b0;
        w_pend_clear = 1'b0;
        w_fill_start = 1'b0;
        w_beat_take  = 1'b0;
        w_fill_done  = 1'b0;
        w_wr_merge   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && !req_write) begin
                    if (w_hit) begin
                        // The cycle right after a fill is the tail of a miss,
                        // not a fresh hit.
                        w_hit_inc = ~r_refill;
                    end else begin
                        w_stall     = 1'b1;
                        w_miss_inc  = 1'b1;
                        w_state_nxt = ST_FILL_REQ;
                    end
                end else if (req_valid && (req_wmask != 4'b0000)) begin
                    w_stall     = 1'b1;
                    w_pend_load = 1'b1;
                    w_state_nxt = ST_WR_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL_REQ: begin
                w_stall     = 1'b1;
                w_mem_valid = 1'b1;
                w_mem_addr  = {w_tag, w_index, 2'b00};
                if (mem_req_ready) begin
                    w_fill_start = 1'b1;
                    w_state_nxt  = ST_FILL_WAIT;
                end else begin
                    w_state_nxt  = ST_FILL_REQ;
                end
            end
            ST_FILL_WAIT: begin
                w_stall     = 1'b1;
                w_beat_take = mem_resp_valid;
                if (mem_resp_valid && (r_beat_cnt == 2'd3)) begin
                    w_fill_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FILL_WAIT;
                end
            end
            ST_WR_SEND: begin
                w_stall     = 1'b1;
                w_mem_valid = 1'b1;
                w_mem_write = 1'b1;
                w_mem_addr  = {req_addr[ADDR_W-1:2], w_k};
                w_mem_wdata = w_req_word[w_k];
                if (mem_req_ready) begin
                    w_pend_clear = 1'b1;
                    if (w_pend_after == 4'b0000) begin
                        // Write-through: only an already-cached line is updated.
                        w_wr_merge  = w_hit;
                        w_state_nxt = ST_WR_DONE;
                    end else begin
                        w_state_nxt = ST_WR_SEND;
                    end
                end else begin
                    w_state_nxt = ST_WR_SEND;
                end
            end
            ST_WR_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending store-word mask: loaded on store entry, one bit retired per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_mask <= 4'b0000;
        end else if (w_pend_load) begin
            r_pend_mask <= req_wmask;
        end else if (w_pend_clear) begin
            r_pend_mask <= w_pend_after;
        end
    end

    // Fill beat counter and buffer for beats 0..2 (beat 3 writes straight in).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= 2'd0;
            r_fill_w0  <= '0;
            r_fill_w1  <= '0;
            r_fill_w2  <= '0;
        end else if (w_fill_start) begin
            r_beat_cnt <= 2'd0;
        end else if (w_beat_take) begin
            r_beat_cnt <= r_beat_cnt + 2'd1;
            case (r_beat_cnt)
                2'd0:    r_fill_w0 <= mem_resp_data;
                2'd1:    r_fill_w1 <= mem_resp_data;
                2'd2:    r_fill_w2 <= mem_resp_data;
                default: r_fill_w2 <= r_fill_w2;
            endcase
        end
    end

    // Marks the IDLE cycle that completes a miss so it is not counted as a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refill <= 1'b0;
        end else if (w_fill_done) begin
            r_refill <= 1'b1;
        end else if (r_state == ST_IDLE) begin
            r_refill <= 1'b0;
        end
    end

    // Saturating read hit and miss counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_hit_inc && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_inc && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    // Per-set valid bits; only a completed fill sets one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_fill_done) begin
            r_valid[w_index] <= 1'b1;
        end
    end

    // Tag and data arrays: written by a completed fill or a store that hits.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_tag[w_index]     <= w_tag;
            r_data[w_index][0] <= r_fill_w0;
            r_data[w_index][1] <= r_fill_w1;
            r_data[w_index][2] <= r_fill_w2;
            r_data[w_index][3] <= mem_resp_data;
        end else if (w_wr_merge) begin
            for (int w = 0; w < 4; w++) begin
                if (req_wmask[w]) begin
                    r_data[w_index][w] <= w_req_word[w];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// loads/stores, checked against a transaction-level cache + memory model.
module tb_dcache_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_write;
    logic [35:0]   req_addr;
    logic [127:0]  req_wdata;
    logic [3:0]    req_wmask;
    logic          stall;
    logic [127:0]  line_data;
    logic [1:0]    line_offset;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_write;
    logic [35:0]   mem_req_addr;
    logic [31:0]   mem_req_wdata;
    logic          mem_resp_valid;
    logic [31:0]   mem_resp_data;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;

    dcache_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .stall          (stall),
        .line_data      (line_data),
        .line_offset    (line_offset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cache contents, counters and backing memory.
    bit          m_valid [16];
    bit [29:0]   m_tag   [16];
    bit [31:0]   m_line  [16][4];
    int unsigned m_hits = 0;
    int unsigned m_miss = 0;
    bit [31:0]   mem [bit [35:0]];

    task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] mem_rd(input bit [35:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // One memory-stage access, acting as backing memory while stalled.
    // Called at a negedge; returns at a negedge after the access is consumed.
    task automatic access(input bit wr, input bit [35:0] a, input bit [127:0] wd,
                          input bit [3:0] wm, input bit rnd, input int rdy_delay,
                          output int done_cyc);
        int        idx;
        bit [29:0] tg;
        bit        hit;
        bit [35:0] q_addr[$];
        bit        q_wr[$];
        bit [31:0] q_wd[$];
        bit [31:0] exp_w[4];
        bit [1:0]  kk;
        int        exp_done;
        int        pend;
        int        beat;
        bit [35:0] base;
        int        hold;
        int        cur_delay;
        bit        prev_wait;
        bit [68:0] prev_req;
        bit        finished;
        bit        was_wr;

        idx = int'(a[5:2]);
        tg  = a[35:6];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_done = -1; pend = 0; beat = 0; base = '0; hold = 0; cur_delay = 0;
        prev_wait = 1'b0; prev_req = '0; finished = 1'b0; done_cyc = -1;

        for (int k = 0; k < 4; k++) begin
            kk = k[1:0];
            exp_w[k] = 32'h0;
            if (!wr && hit) exp_w[k] = m_line[idx][k];
            if (!wr && !hit) exp_w[k] = mem_rd({tg, a[5:2], kk});
            if (wr && wm[k]) begin
                q_addr.push_back({a[35:2], kk});
                q_wr.push_back(1'b1);
                q_wd.push_back(wd[32*k +: 32]);
            end
        end
        if (!wr && !hit) begin
            q_addr.push_back({tg, a[5:2], 2'b00});
            q_wr.push_back(1'b0);
            q_wd.push_back(32'h0);
        end
        if ((!wr && hit) || (wr && wm == 4'b0000)) exp_done = 0;

        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wmask = wm;
        #1;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            // Memory response side: fill beats, or occasional stray beats.
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (pend > 0) begin
                if (!rnd || $urandom_range(0, 2) != 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_rd(base + 36'(beat));
                    beat++;
                    pend--;
                    if (pend == 0) exp_done = cyc + 1;
                end
            end else if (rnd && $urandom_range(0, 7) == 0) begin
                mem_resp_valid = 1'b1;
            end
            // Memory request side.
            mem_req_ready = 1'b0;
            if (prev_wait) begin
                chk_val("req_held_valid", mem_req_valid, 1'b1);
                if (mem_req_valid)
                    chk_val("req_held_fields", {mem_req_write, mem_req_addr, mem_req_wdata}, prev_req);
            end
            prev_wait = 1'b0;
            if (mem_req_valid) begin
                if (q_addr.size() == 0) begin
                    chk_val("req_unexpected", mem_req_valid, 1'b0);
                end else begin
                    if (hold == 0) cur_delay = rnd ? int'($urandom_range(0, 3)) : rdy_delay;
                    if (hold >= cur_delay) begin
                        mem_req_ready = 1'b1;
                        chk_val("req_write", mem_req_write, q_wr[0]);
                        chk_val("req_addr", mem_req_addr, q_addr[0]);
                        if (q_wr[0]) chk_val("req_wdata", mem_req_wdata, q_wd[0]);
                        was_wr = q_wr[0];
                        if (was_wr) begin
                            mem[q_addr[0]] = q_wd[0];
                        end else begin
                            pend = 4; beat = 0; base = q_addr[0];
                        end
                        void'(q_addr.pop_front());
                        void'(q_wr.pop_front());
                        void'(q_wd.pop_front());
                        hold = 0;
                        if (was_wr && q_addr.size() == 0) exp_done = cyc + 1;
                    end else begin
                        hold++;
                        prev_wait = 1'b1;
                        prev_req  = {mem_req_write, mem_req_addr, mem_req_wdata};
                    end
                end
            end else if (rnd) begin
                mem_req_ready = 1'($urandom_range(0, 1));
            end
            // Completion: the stage is released this cycle.
            if (!stall) begin
                chk_val("done_cycle", cyc, exp_done);
                chk_val("beats_left", q_addr.size(), 0);
                chk_val("line_offset", line_offset, a[1:0]);
                if (!wr) chk_val("line_data", line_data, {exp_w[3], exp_w[2], exp_w[1], exp_w[0]});
                done_cyc = cyc;
                finished = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!finished) chk_val("access_timeout", 1'b0, 1'b1);

        req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        if (!wr) begin
            if (hit) begin
                m_hits++;
            end else begin
                m_miss++;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                for (int k = 0; k < 4; k++) m_line[idx][k] = exp_w[k];
            end
        end else if (hit) begin
            for (int k = 0; k < 4; k++)
                if (wm[k]) m_line[idx][k] = wd[32*k +: 32];
        end
        chk_val("hit_count", hit_count, m_hits);
        chk_val("miss_count", miss_count, m_miss);
    endtask

    initial begin
        int        d;
        bit        wr;
        bit [35:0] a;
        bit [127:0] wd;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = 4'b0000; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk);
        chk_val("rst_stall", stall, 1'b0);
        chk_val("rst_mem_valid", mem_req_valid, 1'b0);
        chk_val("rst_mem_addr", mem_req_addr, 36'h0);
        chk_val("rst_hits", hit_count, 32'h0);
        chk_val("rst_misses", miss_count, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // First read miss: fixed beats, ready immediately.
        mem[36'h40] = 32'h11; mem[36'h41] = 32'h22; mem[36'h42] = 32'h33; mem[36'h43] = 32'h44;
        access(1'b0, 36'h40, '0, 4'b0000, 1'b0, 0, d);
        chk_val("miss_latency", d, 6);
        // Immediate hit on the same line.
        access(1'b0, 36'h42, '0, 4'b0000, 1'b0, 0, d);
        chk_val("hit_latency", d, 0);
        // Store hit to words 1 and 3, then re-read.
        wd = '0; wd[63:32] = 32'hAAAA; wd[127:96] = 32'hBBBB;
        access(1'b1, 36'h41, wd, 4'b1010, 1'b0, 0, d);
        chk_val("store_latency", d, 3);
        access(1'b0, 36'h40, '0, 4'b0000, 1'b0, 0, d);
        // Store to an uncached line, then read it (miss, sees stored word).
        wd = '0; wd[31:0] = 32'hCCCC;
        access(1'b1, 36'h80, wd, 4'b0001, 1'b0, 0, d);
        access(1'b0, 36'h80, '0, 4'b0000, 1'b0, 0, d);
        // Zero-mask store: no traffic, no stall.
        access(1'b1, 36'h80, wd, 4'b0000, 1'b0, 0, d);
        // Fill with ready held low for 5 cycles.
        access(1'b0, 36'h1C4, '0, 4'b0000, 1'b0, 5, d);
        chk_val("ready_low_latency", d, 11);

        // Reset in the middle of a fill, after beat 1.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 36'h244; req_wmask = 4'b0000;
        #1;
        chk_val("mf_stall", stall, 1'b1);
        @(posedge clk); @(negedge clk);
        chk_val("mf_req_valid", mem_req_valid, 1'b1);
        chk_val("mf_req_addr", mem_req_addr, 36'h244);
        mem_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h5;
        @(posedge clk); @(negedge clk);
        mem_resp_data = 32'h6;
        @(posedge clk); @(negedge clk);
        mem_resp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_val("mf_rst_req_valid", mem_req_valid, 1'b0);
        chk_val("mf_rst_req_write", mem_req_write, 1'b0);
        chk_val("mf_rst_req_wdata", mem_req_wdata, 32'h0);
        chk_val("mf_rst_stall", stall, 1'b1);
        chk_val("mf_rst_misses", miss_count, 32'h0);
        chk_val("mf_rst_hits", hit_count, 32'h0);
        req_valid = 1'b0;
        #1;
        chk_val("mf_rst_idle_stall", stall, 1'b0);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 0; m_miss = 0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'h7 + 32'(i);
            @(posedge clk); @(negedge clk);
            chk_val("mf_stray_beat", mem_req_valid, 1'b0);
        end
        mem_resp_valid = 1'b0;
        access(1'b0, 36'h244, '0, 4'b0000, 1'b0, 0, d);
        chk_val("mf_reread_latency", d, 6);

        // Randomized mix of loads and stores over a small address pool.
        for (int n = 0; n < 250; n++) begin
            wr = ($urandom_range(0, 9) < 4);
            a  = {30'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            wd = {$urandom, $urandom, $urandom, $urandom};
            access(wr, a, wd, 4'($urandom_range(0, 15)), 1'b1, 0, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Blocking, direct-mapped, write-through, no-write-allocate data cache controller that feeds the memory stage.
- Supplies the 128-bit line (cache_data) and the word offset (line) that the memory stage selects from.
- Supplies the cache_stall that holds the pipeline while a miss or write is outstanding.
- Talks to backing memory over a 32-bit single-beat handshake bus; line fills are 4 in-order beats.

Parameters:
- ADDR_W, 36, word address width (memory is word-addressed).
- SETS, 16, number of lines; index width IDX_W = log2(SETS) = 4.
- BEAT_W, 32, memory bus data width and cache word width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, memory-stage access present; held stable while stall=1.
- req_write, input, 1, 1 = store, 0 = load.
- req_addr, input, ADDR_W, word address; offset = [1:0], index = [5:2], tag = [35:6].
- req_wdata, input, 128, store data; word k = bits [32k+31:32k].
- req_wmask, input, 4, per-word store enable.
- stall, output, 1, hold the memory stage and all upstream stages.
- line_data, output, 128, cached line for req_addr; valid when a read returns stall=0.
- line_offset, output, 2, equals req_addr[1:0].
- mem_req_valid, output, 1, memory request.
- mem_req_ready, input, 1, memory accepts the request.
- mem_req_write, output, 1, 1 = write beat, 0 = line read.
- mem_req_addr, output, ADDR_W, word address.
- mem_req_wdata, output, BEAT_W, write data.
- mem_resp_valid, input, 1, read beat present.
- mem_resp_data, input, BEAT_W, read beat.
- hit_count, output, 32, saturating read-hit counter.
- miss_count, output, 32, saturating read-miss counter.

Behaviour:
- Storage: per set, a valid bit, a 30-bit tag and 4x32-bit data.
- hit = req_valid & valid[index] & (tag match).
- States:
  - IDLE, FILL_REQ, FILL_WAIT, WR_SEND, WR_DONE.
  - IDLE, read hit: stall=0 in the same cycle; line_data = data[index] (combinational); hit_count+1.
  - IDLE, read miss: stall=1; go to FILL_REQ; miss_count+1 (counted once per miss).
  - IDLE, write with req_wmask=0: stall=0, no memory traffic.
  - IDLE, write with req_wmask!=0: stall=1; latch the mask into pend_mask; go to WR_SEND.
  - FILL_REQ: mem_req_valid=1, mem_req_write=0, mem_req_addr={tag,index,2'b00}. Held until mem_req_ready, then go to FILL_WAIT.
  - FILL_WAIT: a 2-bit beat counter captures beats 0..3 into a fill buffer. On beat 3, write the line, tag and valid=1, then go to IDLE. The held request now hits, so stall drops on the next cycle.
  - Read-miss latency from the first IDLE cycle: 1 + (cycles to ready) + (4 beat cycles) + 1.
  - WR_SEND:
    - Select the lowest set bit k of pend_mask.
    - Drive mem_req_valid=1, write=1, addr={req_addr[35:2],k}, wdata=req_wdata word k.
    - On ready, clear bit k.
    - When pend_mask becomes 0 and the line hits at that moment, merge the masked words into data[index]. Then go to WR_DONE.
  - WR_DONE: stall=0 for exactly one cycle; the stage consumes the store; return to IDLE.
  - stall=1 in FILL_REQ, FILL_WAIT and WR_SEND.
- mem_req_valid may be 1 only in FILL_REQ and WR_SEND. Its outputs stay stable until ready.
- mem_resp_valid outside FILL_WAIT is ignored.
- Write misses never allocate.
- Reset (asynchronous, any state, including mid-fill):
  - State returns to IDLE; all valid bits, counters, beat counter and pend_mask are cleared.
  - mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_wdata=0.
  - Tag and data contents are don't-care.
  - After reset, stall follows req_valid, because every access misses.
- Counters saturate at 32'hFFFF_FFFF.
- Reads never issue while a write is in progress; the block is blocking.

Test Plan:
- Reset, then read 0x40: one fill request at 0x40 with ready=1. Beats 0x11,0x22,0x33,0x44. Required: line_data=0x00000044_00000033_00000022_00000011, stall=0 one cycle after beat 3, miss_count=1.
- Read 0x42 immediately after: stall=0 same cycle, line_offset=2, hit_count=1, no mem_req_valid.
- Store to 0x41 with mask 4'b1010, data word1=0xAAAA, word3=0xBBBB: beats to 0x41 then 0x43, in that order. One WR_DONE cycle follows. A re-read of 0x40 hits with words 1 and 3 updated.
- Store to uncached 0x80, mask 4'b0001: a single write beat, valid[0] (index of 0x80) stays 0. A read of 0x80 then misses.
- Fill with mem_req_ready low for 5 cycles: mem_req_addr stays constant and stall stays 1 throughout.
- Assert rst_n low after beat 1 of a fill: state returns to IDLE and mem_req_valid=0. Later beats are ignored; a re-read misses again.
